bcd2bin_seq: RTL and testbench

Digit-serial converter from sign-magnitude BCD to signed two's-complement binary. It is the inverse of the team's binary-to-BCD display path. Input word layout: [4*NDIG+3 : 4*NDIG] = sign nibble (4'd0 = non-negative, 4'd5 = negative); below that, NDIG decimal digits, MSD first. It sits between the keypad/BCD entry logic and the arithmetic datapath, with valid/ready handshakes on both sides and an error flag for malformed codes.

---
 rtl/bcd_pkg.sv | 15 +
 rtl/bcd_digit_mac.sv | 11 +
 rtl/bcd2bin_seq.sv | 102 ++++++++++
 tb/tb_bcd2bin_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD codes and converter state encoding.
// The sign codes are also used by the binary-to-BCD display path.
package bcd_pkg;
   localparam logic [3:0] SIGN_POS      = 4'd0;
   localparam logic [3:0] SIGN_NEG      = 4'd5;
   localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CHECK = 3'd1,
      ACC   = 3'd2,
      SIGN  = 3'd3,
      DONE  = 3'd4
   } state_t;
endpackage

// File: rtl/bcd_digit_mac.sv
// Combinational decimal multiply-accumulate step: acc*10 + digit, NW bits wide.
module bcd_digit_mac #(
   parameter int NW = 16
) (
   input  logic [NW-1:0] acc,
   input  logic [3:0]    digit,
   output logic [NW-1:0] acc_nx
);
   // x10 as x8 + x2; the caller's parameter range guarantees no overflow
   assign acc_nx = (acc << 3) + (acc << 1) + {{(NW-4){1'b0}}, digit};
endmodule

// File: rtl/bcd2bin_seq.sv
// Digit-serial sign-magnitude BCD to two's-complement converter, MSD first,
// with valid/ready on both sides and an error flag for malformed words.
module bcd2bin_seq
   import bcd_pkg::*;
#(
   parameter int NDIG = 4,
   parameter int NW   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*(NDIG+1)-1:0] bcd_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [NW-1:0]         n_out,
   output logic                  err
);
   localparam int WW = 4*(NDIG+1);
   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

   state_t          state, state_nx;
   logic [WW-1:0]   word;
   logic [NW-1:0]   acc, acc_nx, n_q;
   logic [IW-1:0]   idx;
   logic [3:0]      dig, sgn;
   logic            bad, err_q;

   assign sgn = word[4*NDIG +: 4];

   always_comb begin
      bad = (sgn != SIGN_POS) && (sgn != SIGN_NEG);
      for (int i = 0; i < NDIG; i++)
         if (word[4*i +: 4] > BCD_DIGIT_MAX) bad = 1'b1;
   end

   // idx counts down from NDIG-1, so digit idx is the current MSD-first digit
   always_comb begin
      dig = '0;
      for (int i = 0; i < NDIG; i++)
         if (idx == IW'(i)) dig = word[4*i +: 4];
   end

   bcd_digit_mac #(.NW(NW)) u_mac (
      .acc    (acc),
      .digit  (dig),
      .acc_nx (acc_nx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = CHECK;
         CHECK:   state_nx = bad ? DONE : ACC;
         ACC:     if (idx == '0) state_nx = SIGN;
         SIGN:    state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word  <= '0;
         acc   <= '0;
         idx   <= '0;
         n_q   <= '0;
         err_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               word <= bcd_in;
               acc  <= '0;
               idx  <= IW'(NDIG-1);
            end
            CHECK: if (bad) begin
               n_q   <= '0;
               err_q <= 1'b1;
            end
            ACC: begin
               acc <= acc_nx;
               idx <= idx - IW'(1);
            end
            SIGN: begin
               n_q   <= (sgn == SIGN_NEG) ? -acc : acc;
               err_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign n_out     = n_q;
   assign err       = err_q;
endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: scoreboard of expected {err,n_out}
// pushed at stimulus time and popped when a result is presented.
module tb_bcd2bin_seq;
   localparam int NDIG = 4;
   localparam int NW   = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [19:0]   bcd_in = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [NW-1:0] n_out;
   logic          err;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [16:0] sb[$];

   bcd2bin_seq #(.NDIG(NDIG), .NW(NW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bcd_in    (bcd_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .n_out     (n_out),
      .err       (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Drive a word until accepted; returns the cycle number of the accept edge.
   task automatic send(input logic [19:0] w, input bit keep, output int ac, output bit ok);
      ok = 1'b0;
      ac = 0;
      bcd_in = w;
      in_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (in_ready) begin
            step();
            ac = cyc;
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!keep) in_valid = 1'b0;
      bcd_in = 20'($urandom);
   endtask

   task automatic wait_valid(output int c, output bit ok);
      ok = 1'b0;
      c = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) begin
            c = cyc;
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (n_out !== 16'd0)    begin bad++; $display("FAIL reset_n_out got=%h want=0", n_out); end
      total++; if (err !== 1'b0)       begin bad++; $display("FAIL reset_err got=%b want=0", err); end
   endtask

   // Convert one word with out_ready high, checking value, latency and pulse width.
   task automatic test_convert(input string nm, input logic [19:0] w,
                               input logic [15:0] en, input logic ee, input int lat);
      int ac, vc;
      bit ok1, ok2;
      logic [16:0] exp;
      out_ready = 1'b1;
      sb.push_back({ee, en});
      send(w, 1'b0, ac, ok1);
      wait_valid(vc, ok2);
      exp = sb.pop_front();
      total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL %s_timeout got=%b%b want=11", nm, ok1, ok2); end
      total++; if (n_out !== exp[15:0]) begin bad++; $display("FAIL %s_n_out got=%h want=%h", nm, n_out, exp[15:0]); end
      total++; if (err !== exp[16]) begin bad++; $display("FAIL %s_err got=%b want=%b", nm, err, exp[16]); end
      total++; if (vc - ac !== lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", nm, vc - ac, lat); end
      step();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL %s_release got=v%b r%b want=v0 r1", nm, out_valid, in_ready);
      end
   endtask

   task automatic test_valid();
      test_convert("pos1234", 20'h01234, 16'd1234, 1'b0, 6);
      test_convert("neg9999", 20'h59999, 16'hD8F1, 1'b0, 6);
      test_convert("zero",    20'h00000, 16'h0000, 1'b0, 6);
      test_convert("negzero", 20'h50000, 16'h0000, 1'b0, 6);
   endtask

   task automatic test_error();
      test_convert("baddigit", 20'h012A4, 16'h0000, 1'b1, 1);
      test_convert("badsign",  20'h31234, 16'h0000, 1'b1, 1);
   endtask

   task automatic test_backpressure();
      int ac, vc;
      bit ok1, ok2;
      logic [16:0] exp;
      out_ready = 1'b0;
      sb.push_back({1'b0, 16'd42});
      send(20'h00042, 1'b0, ac, ok1);
      wait_valid(vc, ok2);
      exp = sb.pop_front();
      total++; if (!(ok1 && ok2)) begin bad++; $display("FAIL bp_timeout got=%b%b want=11", ok1, ok2); end
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         bcd_in = 20'h00099;
         step();
         total++; if (out_valid !== 1'b1 || n_out !== exp[15:0] || err !== exp[16] || in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_hold%0d got=v%b n%h e%b r%b want=v1 n%h e%b r0",
                            i, out_valid, n_out, err, in_ready, exp[15:0], exp[16]);
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL bp_release got=v%b r%b want=v0 r1", out_valid, in_ready);
      end
      step(); step();
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL bp_no_extra got=v%b r%b want=v0 r1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      int ac, vc;
      bit ok1, ok2;
      out_ready = 1'b1;
      send(20'h05678, 1'b0, ac, ok1);
      step();          // CHECK -> ACC
      step();          // now in 2nd ACC cycle
      #2 rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || n_out !== 16'd0 || err !== 1'b0) begin
         bad++; $display("FAIL rstmid_outputs got=v%b r%b n%h e%b want=v0 r1 n0000 e0",
                         out_valid, in_ready, n_out, err);
      end
      @(negedge clk); rst_n = 1'b1;
      step();
      total++; if (!ok1) begin bad++; $display("FAIL rstmid_accept got=%b want=1", ok1); end
      sb.push_back({1'b0, 16'hFFF9});
      send(20'h50007, 1'b0, ac, ok1);
      wait_valid(vc, ok2);
      begin
         logic [16:0] exp;
         exp = sb.pop_front();
         total++; if (!(ok1 && ok2) || n_out !== exp[15:0] || err !== exp[16]) begin
            bad++; $display("FAIL rstmid_neg7 got=n%h e%b want=n%h e%b", n_out, err, exp[15:0], exp[16]);
         end
      end
      total++; if (vc - ac !== 6) begin bad++; $display("FAIL rstmid_latency got=%0d want=6", vc - ac); end
      step();
   endtask

   task automatic test_back_to_back();
      int outs[3];
      out_ready = 1'b1;
      fork
         begin
            int ac;
            bit ok;
            for (int i = 0; i < 3; i++) begin
               sb.push_back({1'b0, 16'(i + 1)});
               send(20'(i + 1), 1'b1, ac, ok);
               total++; if (!ok) begin bad++; $display("FAIL b2b_accept%0d got=0 want=1", i); end
            end
            in_valid = 1'b0;
         end
         begin
            int vc;
            bit ok;
            logic [16:0] exp;
            for (int i = 0; i < 3; i++) begin
               wait_valid(vc, ok);
               outs[i] = vc;
               exp = (sb.size() > 0) ? sb.pop_front() : 17'h1FFFF;
               total++; if (!ok || n_out !== exp[15:0] || err !== exp[16]) begin
                  bad++; $display("FAIL b2b_result%0d got=n%h e%b want=n%h e%b", i, n_out, err, exp[15:0], exp[16]);
               end
               step();
            end
         end
      join
      for (int i = 1; i < 3; i++) begin
         total++; if (outs[i] - outs[i-1] !== 8) begin
            bad++; $display("FAIL b2b_spacing%0d got=%0d want=8", i, outs[i] - outs[i-1]);
         end
      end
   endtask

   initial begin
      #12 rst_n = 1'b1;
      step();
      test_reset();
      test_valid();
      test_error();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end
endmodule
